// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch front end: owns the PC, fetches one word at a time over a req/ack
// handshake, holds it for the control unit and resolves the next PC on accept.
module instruction_fetch_unit #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [10:0]       instruction_part,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              Branch,
  input  logic              unconditional_branch,
  input  logic              zero,
  output logic              halted,
  output logic [31:0]       retired_count
);

  typedef enum logic [1:0] {RESET_S, FETCH, HOLD, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]       count_q, count_d;

  // B uses imm26, CBZ/B.cond use imm19; both are word offsets.
  function automatic logic [ADDR_W-1:0] calc_next_pc(
    input logic [31:0]       ins,
    input logic [ADDR_W-1:0] pc,
    input logic              br,
    input logic              ub,
    input logic              z
  );
    logic [ADDR_W-1:0] imm;
    if (ub) imm = {{(ADDR_W-26){ins[25]}}, ins[25:0]};
    else    imm = {{(ADDR_W-19){ins[23]}}, ins[23:5]};
    if (ub | (br & z)) return pc + (imm << 2);
    return pc + ADDR_W'(4);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_S;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          // An all-zero word is the halt marker; PC is left where it was.
          if (instr_q == 32'h0) begin
            state_d = HALT;
          end else begin
            pc_d    = calc_next_pc(instr_q, instr_pc_q, Branch, unconditional_branch, zero);
            state_d = FETCH;
          end
        end
      end
      HALT: halted = 1'b1;
      default: state_d = RESET_S;
    endcase
  end

  assign imem_addr        = pc_q;
  assign instr            = instr_q;
  assign instruction_part = instr_q[31:21];
  assign instr_pc         = instr_pc_q;
  assign retired_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory handshake, stalls, branches,
// PC wrap, halt and asynchronous reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [10:0] instruction_part;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        Branch;
  logic        ub;
  logic        zero;
  logic        halted;
  logic [31:0] retired_count;

  logic        req2, ack2, ready2, valid2, halted2;
  logic [63:0] addr2, ipc2;
  logic [31:0] rdata2, instr2, cnt2;
  logic [10:0] part2;
  logic        lo = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instruction_part(instruction_part), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Branch(Branch), .unconditional_branch(ub), .zero(zero),
    .halted(halted), .retired_count(retired_count)
  );

  instruction_fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instr(instr2),
    .instruction_part(part2), .instr_pc(ipc2), .instr_valid(valid2),
    .instr_ready(ready2), .Branch(lo), .unconditional_branch(lo), .zero(lo),
    .halted(halted2), .retired_count(cnt2)
  );

  task automatic do_reset();
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    Branch = 1'b0; ub = 1'b0; zero = 1'b0; ack2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic serve(input int delay, input logic [31:0] word,
                       output logic [63:0] addr, output bit stable);
    addr = imem_addr; stable = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (imem_addr !== addr || imem_req !== 1'b1) stable = 1'b0;
    end
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic accept(input int stall, input logic b, input logic u, input logic z,
                        output bit held);
    logic [31:0] w;
    w = instr; held = (instr_valid === 1'b1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (instr !== w || instr_valid !== 1'b1) held = 1'b0;
    end
    instr_ready = 1'b1; Branch = b; ub = u; zero = z;
    @(negedge clk);
    instr_ready = 1'b0; Branch = 1'b0; ub = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h8B02_0020; instr_ready = 1'b0;
    Branch = 1'b0; ub = 1'b0; zero = 1'b0; ack2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: req/valid/halted=%b expected 000", {imem_req, instr_valid, halted});
    end
    checks++;
    if (instr !== 32'h0 || instr_pc !== 64'h0 || retired_count !== 32'h0 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL reset_data: instr=%h pc=%h cnt=%0d addr=%h expected all 0", instr, instr_pc, retired_count, imem_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h expected 1 and 0", imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instruction_part !== 11'b10001011000 || instr_pc !== 64'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL first_valid: valid=%b part=%b pc=%h req=%b expected 1 10001011000 0 0", instr_valid, instruction_part, instr_pc, imem_req);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (imem_addr !== 64'h4 || imem_req !== 1'b1 || retired_count !== 32'd1) begin
      errors++; $display("FAIL second_addr: addr=%h req=%b cnt=%0d expected 4 1 1", imem_addr, imem_req, retired_count);
    end
  endtask

  task automatic test_stream();
    logic [31:0] words [4];
    logic [63:0] a;
    bit ok, st, held;
    words[0] = 32'h8B02_0020; words[1] = 32'h8B03_0041;
    words[2] = 32'hCB02_0062; words[3] = 32'h9100_0483;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_req(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_req%0d: req=%b expected 1 within 20 cycles", k, imem_req); end
      serve(3, words[k], a, st);
      checks++;
      if (a !== 64'(4 * k) || !st) begin
        errors++; $display("FAIL stream_addr%0d: addr=%h stable=%b expected %h stable=1", k, a, st, 64'(4 * k));
      end
      checks++;
      if (instr !== words[k]) begin errors++; $display("FAIL stream_instr%0d: instr=%h expected %h", k, instr, words[k]); end
      accept(2, 1'b0, 1'b0, 1'b0, held);
      checks++;
      if (!held) begin errors++; $display("FAIL stream_hold%0d: held=%b expected 1", k, held); end
    end
    checks++;
    if (retired_count !== 32'd4 || imem_addr !== 64'h10) begin
      errors++; $display("FAIL stream_end: cnt=%0d addr=%h expected 4 10", retired_count, imem_addr);
    end
  endtask

  task automatic test_uncond_branch();
    logic [63:0] a;
    bit ok, st, held;
    wait_req(ok);
    serve(0, 32'h1400_0003, a, st);
    accept(0, 1'b0, 1'b1, 1'b0, held);
    checks++;
    if (!ok || a !== 64'h10 || imem_addr !== 64'h1C) begin
      errors++; $display("FAIL uncond_branch: from=%h next=%h expected 10 -> 1c", a, imem_addr);
    end
  endtask

  task automatic test_cond_branch();
    logic [63:0] a;
    bit ok, st, held;
    wait_req(ok); serve(1, 32'h8B02_0020, a, st); accept(0, 1'b0, 1'b0, 1'b0, held);
    checks++;
    if (imem_addr !== 64'h20) begin errors++; $display("FAIL cond_setup: addr=%h expected 20", imem_addr); end
    wait_req(ok); serve(0, 32'hB4FF_FFC0, a, st); accept(1, 1'b1, 1'b0, 1'b1, held);
    checks++;
    if (imem_addr !== 64'h18) begin errors++; $display("FAIL cond_taken: addr=%h expected 18", imem_addr); end
    wait_req(ok); serve(0, 32'h8B02_0020, a, st); accept(0, 1'b0, 1'b0, 1'b0, held);
    wait_req(ok); serve(0, 32'h8B02_0020, a, st); accept(0, 1'b0, 1'b0, 1'b0, held);
    wait_req(ok); serve(0, 32'hB4FF_FFC0, a, st);
    checks++;
    if (a !== 64'h20) begin errors++; $display("FAIL cond_refetch: addr=%h expected 20", a); end
    accept(0, 1'b1, 1'b0, 1'b0, held);
    checks++;
    if (imem_addr !== 64'h24) begin errors++; $display("FAIL cond_not_taken: addr=%h expected 24", imem_addr); end
  endtask

  task automatic test_branch_outside_hold();
    logic [63:0] a;
    bit ok, st, held;
    do_reset();
    wait_req(ok);
    Branch = 1'b1; zero = 1'b1; ub = 1'b1;
    serve(3, 32'h8B02_0020, a, st);
    accept(2, 1'b0, 1'b0, 1'b0, held);
    checks++;
    if (a !== 64'h0 || !st || !held || imem_addr !== 64'h4) begin
      errors++; $display("FAIL branch_ignored: addr=%h stable=%b held=%b next=%h expected 0 1 1 4", a, st, held, imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req2 === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || addr2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: req=%b addr=%h expected 1 fffffffffffffffc", req2, addr2);
    end
    ack2 = 1'b1; rdata2 = 32'h8B02_0020;
    @(negedge clk);
    ack2 = 1'b0; ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 64'h0 || ipc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_next: req=%b addr=%h ipc=%h expected 1 0 fffffffffffffffc", req2, addr2, ipc2);
    end
  endtask

  task automatic test_halt();
    logic [63:0] a;
    bit ok, st, held, req_seen;
    do_reset();
    wait_req(ok); serve(0, 32'h0, a, st); accept(1, 1'b0, 1'b0, 1'b0, held);
    checks++;
    if (halted !== 1'b1 || retired_count !== 32'd1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_enter: halted=%b cnt=%0d req=%b expected 1 1 0", halted, retired_count, imem_req);
    end
    req_seen = 1'b0;
    imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1) req_seen = 1'b1;
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    checks++;
    if (req_seen || retired_count !== 32'd1) begin
      errors++; $display("FAIL halt_stay: left_halt=%b cnt=%0d expected 0 1", req_seen, retired_count);
    end
  endtask

  task automatic test_reset_midfetch();
    logic [63:0] a;
    bit ok, st, held;
    do_reset();
    wait_req(ok); serve(0, 32'h8B02_0020, a, st); accept(0, 1'b0, 1'b0, 1'b0, held);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000 || retired_count !== 32'd0 ||
        instr !== 32'h0 || instr_pc !== 64'h0 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL async_reset: req=%b valid=%b halted=%b cnt=%0d instr=%h addr=%h expected all 0",
                         imem_req, instr_valid, halted, retired_count, instr, imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL late_ack: req=%b valid=%b instr=%h addr=%h expected 1 0 0 0", imem_req, instr_valid, instr, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_uncond_branch();
    test_cond_branch();
    test_branch_outside_hold();
    test_wrap();
    test_halt();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
